// File: rtl/vcpu32_icache_pkg.sv
// rtl/vcpu32_icache_pkg.sv - shared state encoding, default geometry and constants for the instruction cache
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

package vcpu32_icache_pkg;

  localparam int DEF_WORD_LENGTH = `WORD_LENGTH;
  localparam int DEF_ADR_WIDTH   = 32;
  localparam int DEF_LINE_WORDS  = 4;
  localparam int DEF_NUM_LINES   = 64;

  // Instructions are word aligned, so the two lowest address bits select a byte in the word.
  localparam int BYTE_OFF_W = 2;

  localparam logic [DEF_WORD_LENGTH-1:0] ZERO = '0;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL,
    RESPOND,
    FLUSH
  } state_t;

endpackage

// File: rtl/icache_line_ram.sv
// rtl/icache_line_ram.sv - tag and data arrays of the instruction cache, synchronous read, single write port
module icache_line_ram #(
  parameter int WORD_LENGTH = 32,
  parameter int TAG_W       = 22,
  parameter int IDX_W       = 6,
  parameter int BEAT_W      = 2
) (
  input  logic                   clk,
  input  logic                   rd_en,
  input  logic [IDX_W-1:0]       rd_idx,
  input  logic [BEAT_W-1:0]      rd_word,
  output logic [TAG_W-1:0]       rd_tag,
  output logic [WORD_LENGTH-1:0] rd_data,
  input  logic                   wr_en,
  input  logic                   wr_tag_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [BEAT_W-1:0]      wr_word,
  input  logic [WORD_LENGTH-1:0] wr_data,
  input  logic [TAG_W-1:0]       wr_tag
);

  localparam int DATA_DEPTH = 2 ** (IDX_W + BEAT_W);
  localparam int TAG_DEPTH  = 2 ** IDX_W;

  logic [WORD_LENGTH-1:0] data_mem [0:DATA_DEPTH-1];
  logic [TAG_W-1:0]       tag_mem  [0:TAG_DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[{wr_idx, wr_word}] <= wr_data;
    end
    if (wr_en && wr_tag_en) begin
      tag_mem[wr_idx] <= wr_tag;
    end
    if (rd_en) begin
      rd_data <= data_mem[{rd_idx, rd_word}];
      rd_tag  <= tag_mem[rd_idx];
    end
  end

endmodule

// File: rtl/icache_fetch_responder.sv
// rtl/icache_fetch_responder.sv - direct-mapped icache answering fetch requests with memory line fill and flush
// Hit/miss counters are built only when ICACHE_STATS_EN is defined.
module icache_fetch_responder
  import vcpu32_icache_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int ADR_WIDTH   = DEF_ADR_WIDTH,
  parameter int LINE_WORDS  = DEF_LINE_WORDS,
  parameter int NUM_LINES   = DEF_NUM_LINES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fReq,
  input  logic [ADR_WIDTH-1:0]   fAdr,
  output logic                   fValid,
  output logic [WORD_LENGTH-1:0] fInstr,
  output logic                   fAlignErr,
  output logic                   fBusy,
  input  logic                   flushReq,
  output logic                   flushDone,
  output logic                   mReq,
  output logic [ADR_WIDTH-1:0]   mAdr,
  input  logic                   mAck,
  input  logic [WORD_LENGTH-1:0] mData
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]            hitCnt,
  output logic [31:0]            missCnt
`endif
);

  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int OFF_W  = BEAT_W + BYTE_OFF_W;
  localparam int TAG_W  = ADR_WIDTH - OFF_W - IDX_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_LINES - 1);

  state_t                 state_q, state_d;
  logic [ADR_WIDTH-1:0]   req_adr_q, req_adr_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [IDX_W-1:0]       flush_idx_q, flush_idx_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic                   fvalid_q, fvalid_d;
  logic                   falign_q, falign_d;
  logic                   flush_done_q, flush_done_d;
  logic [WORD_LENGTH-1:0] finstr_q, finstr_d;
  logic [WORD_LENGTH-1:0] resp_word_q, resp_word_d;

  logic [TAG_W-1:0]       req_tag, rd_tag;
  logic [IDX_W-1:0]       req_idx;
  logic [BEAT_W-1:0]      req_word;
  logic [WORD_LENGTH-1:0] rd_data;
  logic                   misaligned, hit, fill_we, fill_last;

  assign req_tag    = req_adr_q[ADR_WIDTH-1 -: TAG_W];
  assign req_idx    = req_adr_q[OFF_W +: IDX_W];
  assign req_word   = req_adr_q[BYTE_OFF_W +: BEAT_W];
  assign misaligned = |req_adr_q[BYTE_OFF_W-1:0];
  assign hit        = valid_q[req_idx] && (rd_tag == req_tag);
  assign fill_we    = (state_q == FILL) && mAck;
  assign fill_last  = fill_we && (beat_q == LAST_BEAT);

  // The array is addressed straight from fAdr while idle so LOOKUP sees tag and word one cycle later.
  icache_line_ram #(
    .WORD_LENGTH(WORD_LENGTH),
    .TAG_W      (TAG_W),
    .IDX_W      (IDX_W),
    .BEAT_W     (BEAT_W)
  ) u_line_ram (
    .clk      (clk),
    .rd_en    (state_q == IDLE),
    .rd_idx   (fAdr[OFF_W +: IDX_W]),
    .rd_word  (fAdr[BYTE_OFF_W +: BEAT_W]),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_we),
    .wr_tag_en(fill_last),
    .wr_idx   (req_idx),
    .wr_word  (beat_q),
    .wr_data  (mData),
    .wr_tag   (req_tag)
  );

  assign fValid    = fvalid_q;
  assign fInstr    = finstr_q;
  assign fAlignErr = falign_q;
  assign flushDone = flush_done_q;
  assign fBusy     = !(state_q inside {IDLE, LOOKUP});
  assign mReq      = (state_q == FILL);
  assign mAdr      = mReq ? {req_tag, req_idx, beat_q, {BYTE_OFF_W{1'b0}}} : '0;

  always_comb begin
    state_d      = state_q;
    req_adr_d    = req_adr_q;
    beat_d       = beat_q;
    flush_idx_d  = flush_idx_q;
    valid_d      = valid_q;
    resp_word_d  = resp_word_q;
    finstr_d     = finstr_q;
    fvalid_d     = 1'b0;
    falign_d     = 1'b0;
    flush_done_d = 1'b0;
    flush_pend_d = flush_pend_q | (flushReq && (state_q inside {LOOKUP, FILL, RESPOND}));

    case (state_q)
      IDLE: begin
        if (flushReq || flush_pend_q) begin
          state_d      = FLUSH;
          flush_idx_d  = '0;
          flush_pend_d = 1'b0;
        end else if (fReq && !fvalid_q) begin
          // fvalid_q gates the request that is being answered in this very cycle.
          state_d   = LOOKUP;
          req_adr_d = fAdr;
        end
      end
      LOOKUP: begin
        if (misaligned) begin
          fvalid_d = 1'b1;
          falign_d = 1'b1;
          finstr_d = WORD_LENGTH'(ZERO);
          state_d  = IDLE;
        end else if (hit) begin
          fvalid_d = 1'b1;
          finstr_d = rd_data;
          state_d  = IDLE;
        end else begin
          beat_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (mAck) begin
          if (beat_q == req_word) begin
            resp_word_d = mData;
          end
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            valid_d[req_idx] = 1'b1;
            fvalid_d         = 1'b1;
            finstr_d         = (beat_q == req_word) ? mData : resp_word_q;
            state_d          = RESPOND;
          end
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      FLUSH: begin
        valid_d[flush_idx_q] = 1'b0;
        flush_idx_d          = flush_idx_q + 1'b1;
        if (flush_idx_q == LAST_IDX) begin
          flush_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_adr_q    <= '0;
      beat_q       <= '0;
      flush_idx_q  <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      fvalid_q     <= 1'b0;
      falign_q     <= 1'b0;
      flush_done_q <= 1'b0;
      finstr_q     <= '0;
      resp_word_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_adr_q    <= req_adr_d;
      beat_q       <= beat_d;
      flush_idx_q  <= flush_idx_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      fvalid_q     <= fvalid_d;
      falign_q     <= falign_d;
      flush_done_q <= flush_done_d;
      finstr_q     <= finstr_d;
      resp_word_q  <= resp_word_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == LOOKUP) && !misaligned) begin
      if (hit) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hitCnt  = hit_cnt_q;
  assign missCnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_fetch_responder.sv
// tb/tb_icache_fetch_responder.sv - self-checking bench for icache_fetch_responder against a line-level cache model
module tb_icache_fetch_responder;

  logic        clk;
  logic        rst;
  logic        fReq;
  logic [31:0] fAdr;
  logic        fValid;
  logic [31:0] fInstr;
  logic        fAlignErr;
  logic        fBusy;
  logic        flushReq;
  logic        flushDone;
  logic        mReq;
  logic [31:0] mAdr;
  logic        mAck;
  logic [31:0] mData;
`ifdef ICACHE_STATS_EN
  logic [31:0] hitCnt;
  logic [31:0] missCnt;
`endif

  icache_fetch_responder dut (
    .clk      (clk),
    .rst      (rst),
    .fReq     (fReq),
    .fAdr     (fAdr),
    .fValid   (fValid),
    .fInstr   (fInstr),
    .fAlignErr(fAlignErr),
    .fBusy    (fBusy),
    .flushReq (flushReq),
    .flushDone(flushDone),
    .mReq     (mReq),
    .mAdr     (mAdr),
    .mAck     (mAck),
    .mData    (mData)
`ifdef ICACHE_STATS_EN
    ,
    .hitCnt   (hitCnt),
    .missCnt  (missCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Backing memory and cache model: one valid flag and tag per line.
  logic [31:0] mem [logic [31:0]];
  bit   [63:0] mvalid;
  logic [21:0] mtag [64];

  logic [31:0] beat_log [$];
  int          ack_delay;
  bit          noise_en;
  int          wait_cnt;

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Memory side: each beat is acknowledged after ack_delay waiting cycles; stray acks while idle when noise_en.
  initial begin
    mAck = 1'b0;
    mData = '0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (mReq) begin
        if (wait_cnt >= ack_delay) begin
          mAck = 1'b1;
          mData = mem_get(mAdr);
          beat_log.push_back(mAdr);
          wait_cnt = 0;
        end else begin
          mAck = 1'b0;
          wait_cnt++;
        end
      end else begin
        mAck = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        mData = $urandom;
        wait_cnt = 0;
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input int d, input int flush_beat, input bit drop_early);
    logic [5:0]  idx;
    logic [21:0] tg;
    logic [31:0] base;
    bit          aligned, hit, flushed;
    int          cyc;
    idx     = a[9:4];
    tg      = a[31:10];
    base    = {a[31:4], 4'h0};
    aligned = (a[1:0] == 2'b00);
    hit     = aligned && mvalid[idx] && (mtag[idx] == tg);
    flushed = 1'b0;
    ack_delay = d;
    beat_log.delete();
    @(negedge clk);
    fReq = 1'b1;
    fAdr = a;
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (flushReq) flushReq = 1'b0;
      if (fValid) break;
      if (drop_early && cyc == 3) fReq = 1'b0;
      if (!flushed && flush_beat >= 0 && beat_log.size() >= flush_beat) begin
        flushReq = 1'b1;
        flushed = 1'b1;
      end
    end
    fReq = 1'b0;
    chk("fetch_done", fValid, 1);
    chk("align_err", fAlignErr, !aligned);
    chk("instr", fInstr, aligned ? mem_get(a) : 32'h0);
    chk("beat_count", beat_log.size(), (aligned && !hit) ? 4 : 0);
    if (aligned && !hit) begin
      for (int k = 0; k < beat_log.size(); k++) chk("beat_adr", beat_log[k], base + 32'(4 * k));
    end
    chk("latency", cyc, (aligned && !hit) ? 2 + 4 * (d + 1) : 2);
    if (aligned && !hit) begin
      mvalid[idx] = 1'b1;
      mtag[idx] = tg;
    end
    if (flushed) begin
      cyc = 0;
      while (!flushDone && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      chk("flush_after_fill_lat", cyc, 66);
      @(negedge clk);
      chk("flush_done_pulse", flushDone, 0);
      mvalid = '0;
    end
  endtask

  initial begin
    int cyc, pulses, first;
    logic [31:0] a;
    rst = 1'b0;
    fReq = 1'b0;
    fAdr = '0;
    flushReq = 1'b0;
    ack_delay = 0;
    noise_en = 1'b0;
    mvalid = '0;
    for (int k = 0; k < 4; k++) mem[32'h100 + 32'(4 * k)] = 32'hA0 + 32'(k);

    repeat (3) @(negedge clk);
    chk("rst_fValid", fValid, 0);
    chk("rst_fAlignErr", fAlignErr, 0);
    chk("rst_fBusy", fBusy, 0);
    chk("rst_flushDone", flushDone, 0);
    chk("rst_mReq", mReq, 0);
    chk("rst_fInstr", fInstr, 0);
    chk("rst_mAdr", mAdr, 0);
    rst = 1'b1;
    @(negedge clk);

    fetch(32'h100, 0, -1, 0);
    fetch(32'h104, 0, -1, 0);
    fetch(32'h500, 1, -1, 0);
    fetch(32'h100, 0, -1, 0);
    fetch(32'h102, 0, -1, 0);
    fetch(32'h500, 0, 2, 0);
    fetch(32'h100, 2, -1, 0);

    // Reset while the second beat of a fill is outstanding.
    ack_delay = 1;
    beat_log.delete();
    @(negedge clk);
    fReq = 1'b1;
    fAdr = 32'h500;
    cyc = 0;
    while (beat_log.size() < 1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_fill_reached", beat_log.size() >= 1, 1);
    @(negedge clk);
    rst = 1'b0;
    fReq = 1'b0;
    #1;
    chk("rst_mid_mReq", mReq, 0);
    chk("rst_mid_fBusy", fBusy, 0);
    @(negedge clk);
    rst = 1'b1;
    mvalid = '0;
    fetch(32'h100, 0, -1, 0);
    fetch(32'h500, 0, -1, 0);

    // Idle flush with a second request merged into the active one.
    @(negedge clk);
    flushReq = 1'b1;
    pulses = 0;
    first = -1;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      flushReq = (i == 11);
      if (flushDone) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (i == 30) chk("flush_busy", fBusy, 1);
    end
    chk("flush_pulses", pulses, 1);
    chk("flush_latency", first, 65);
    chk("flush_idle", fBusy, 0);
    mvalid = '0;

    noise_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(16, 19)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      fetch(a, $urandom_range(0, 2), -1, ($urandom_range(0, 3) == 0));
    end
    noise_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
